// File: rtl/pci_arbiter_if.sv
// Bus-side signal bundle between the PCI arbiter and the agents it serves.
// The arbiter connects through the slave modport; agents (or a bench) use master.
interface pci_arbiter_if #(
    parameter int N_MASTERS = 4
);
    localparam int OWNER_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] REQ;
    logic                 FRAME;
    logic                 IRDY;
    logic [N_MASTERS-1:0] GNT;
    logic [OWNER_W-1:0]   GNT_OWNER;
    logic                 BUS_IDLE;
    logic                 TIMEOUT_EVT;

    modport master (
        output REQ, FRAME, IRDY,
        input  GNT, GNT_OWNER, BUS_IDLE, TIMEOUT_EVT
    );

    modport slave (
        input  REQ, FRAME, IRDY,
        output GNT, GNT_OWNER, BUS_IDLE, TIMEOUT_EVT
    );
endinterface

// File: rtl/pci_arbiter.sv
// Round-robin central PCI arbiter with bus parking and unused-grant timeout.
// Every owner change passes through HANDOVER so at most one GNT is ever low.
module pci_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int GNT_TIMEOUT = 16,
    parameter int PARK_ID     = 0
) (
    input  logic          CLK,
    input  logic          RST,
    pci_arbiter_if.slave  bus
);
    localparam int OWNER_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int TIMER_W = $clog2(GNT_TIMEOUT);
    localparam logic [OWNER_W-1:0] PARK_IDX  = OWNER_W'(PARK_ID);
    localparam logic [N_MASTERS-1:0] ALL_OFF = '1;

    typedef enum logic [1:0] {HANDOVER, PARK, GRANTED, BUSY} state_t;

    state_t               state;
    logic [N_MASTERS-1:0] gnt;
    logic [OWNER_W-1:0]   owner;
    logic [OWNER_W-1:0]   rr_ptr;
    logic [TIMER_W-1:0]   timer;
    logic                 bus_idle;
    logic                 timeout_evt;

    logic [OWNER_W-1:0]   winner;
    logic                 any_req;
    logic [N_MASTERS-1:0] owner_mask;
    logic [N_MASTERS-1:0] park_mask;
    logic                 others_req;
    logic                 owner_req;
    logic                 park_alone;

    // Scan downward from pointer+N to pointer+1 so the last hit is the first
    // requester found upward from pointer+1.
    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            automatic int idx = (int'(rr_ptr) + k) % N_MASTERS;
            if (!bus.REQ[idx]) begin
                winner  = OWNER_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign owner_mask = N_MASTERS'(1) << owner;
    assign park_mask  = N_MASTERS'(1) << PARK_IDX;
    assign others_req = |(~bus.REQ & ~owner_mask);
    assign owner_req  = ~bus.REQ[owner];
    assign park_alone = (~bus.REQ == park_mask);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= HANDOVER;
            gnt         <= ALL_OFF;
            owner       <= PARK_IDX;
            rr_ptr      <= PARK_IDX;
            timer       <= '0;
            bus_idle    <= 1'b1;
            timeout_evt <= 1'b0;
        end else begin
            bus_idle    <= bus.FRAME & bus.IRDY;
            timeout_evt <= 1'b0;
            case (state)
                HANDOVER: begin
                    // A FRAME seen here is illegal; wait for the bus to go idle.
                    if (!bus.FRAME || !bus.IRDY) begin
                        gnt <= ALL_OFF;
                    end else if (any_req) begin
                        gnt   <= ~(N_MASTERS'(1) << winner);
                        owner <= winner;
                        timer <= '0;
                        state <= GRANTED;
                    end else begin
                        gnt   <= ~park_mask;
                        owner <= PARK_IDX;
                        timer <= '0;
                        state <= PARK;
                    end
                end
                PARK: begin
                    if (!bus.FRAME) begin
                        rr_ptr <= owner;
                        state  <= BUSY;
                    end else if (others_req && bus_idle) begin
                        gnt   <= ALL_OFF;
                        state <= HANDOVER;
                    end else if (park_alone) begin
                        timer <= '0;
                        state <= GRANTED;
                    end
                end
                GRANTED: begin
                    // FRAME beats timeout, timeout beats an owner REQ release.
                    if (!bus.FRAME) begin
                        rr_ptr <= owner;
                        state  <= BUSY;
                    end else if (timer == TIMER_W'(GNT_TIMEOUT - 1)) begin
                        timeout_evt <= 1'b1;
                        gnt         <= ALL_OFF;
                        state       <= HANDOVER;
                    end else if (!owner_req) begin
                        gnt   <= ALL_OFF;
                        state <= HANDOVER;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.FRAME && bus.IRDY) begin
                        gnt   <= ALL_OFF;
                        state <= HANDOVER;
                    end else if (others_req || !owner_req) begin
                        gnt <= ALL_OFF;
                    end
                end
                default: begin
                    gnt   <= ALL_OFF;
                    state <= HANDOVER;
                end
            endcase
        end
    end

    assign bus.GNT         = gnt;
    assign bus.GNT_OWNER   = owner;
    assign bus.BUS_IDLE    = bus_idle;
    assign bus.TIMEOUT_EVT = timeout_evt;
endmodule
